// File: rtl/video_pkg.sv
// Shared types and helpers for the video memory arbiter family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package video_pkg;

   // Arbiter sequencing: pick a winner, hold the memory request, pulse the ack
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } arb_state_e;

   // Slot counter saturates so a long layer-only stretch cannot wrap past the CPU threshold
   localparam int              SLOT_W   = 4;
   localparam logic [SLOT_W-1:0] SLOT_MAX = 4'd15;

   localparam int              OVR_W    = 8;
   localparam logic [OVR_W-1:0]  OVR_MAX  = 8'hFF;

   // Requester ids cover every layer plus one extra code for the CPU
   function automatic int id_width(input int num_req);
      return $clog2(num_req + 1);
   endfunction

   // The CPU takes the id just past the last layer
   function automatic int cpu_id(input int num_req);
      return num_req;
   endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: returns the first set request strictly after ptr_i, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed and advances ptr_i.
module rr_select #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic          vld_o,
   output logic [PW-1:0] idx_o
);

   int unsigned cand;

   // Scan from farthest to nearest candidate so the nearest hit is the last one written
   always_comb begin
      vld_o = 1'b0;
      idx_o = '0;
      cand  = 0;
      for (int k = N; k >= 1; k--) begin
         cand = (int'(ptr_i) + k) % N;
         if (req_i[PW'(cand)]) begin
            vld_o = 1'b1;
            idx_o = PW'(cand);
         end
      end
   end

endmodule

// File: rtl/video_mem_arbiter.sv
// Shares one VRAM port between NUM_REQ layer fetchers and the CPU, raster-aware.
// Latency: request sampled -> mem_req 1 cycle; mem_ack -> requester ack 1 cycle.
// Backpressure: mem_req held until mem_ack; requesters hold req/addr/data until their ack.
module video_mem_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int ADDR_WIDTH      = 20,
   parameter int DATA_WIDTH      = 32,
   parameter int CPU_SLOT_PERIOD = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          hblank,
   input  logic                          vblank,
   input  logic [NUM_REQ-1:0]            layer_req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] layer_addr,
   output logic [NUM_REQ-1:0]            layer_ack,
   output logic [DATA_WIDTH-1:0]         layer_rdata,
   input  logic                          cpu_req,
   input  logic                          cpu_we,
   input  logic [ADDR_WIDTH-1:0]         cpu_addr,
   input  logic [DATA_WIDTH-1:0]         cpu_wdata,
   output logic                          cpu_ack,
   output logic [DATA_WIDTH-1:0]         cpu_rdata,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   input  logic                          mem_ack,
   input  logic [DATA_WIDTH-1:0]         mem_rdata,
   output logic                          line_overrun,
   output logic [7:0]                    overrun_count
);

   import video_pkg::*;

   localparam int                PTR_W       = $clog2(NUM_REQ);
   localparam int                ID_W        = id_width(NUM_REQ);
   localparam logic [ID_W-1:0]   CPU_ID      = ID_W'(cpu_id(NUM_REQ));
   localparam logic [SLOT_W-1:0] SLOT_PERIOD = SLOT_W'(CPU_SLOT_PERIOD);

   arb_state_e              state_q;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic [SLOT_W-1:0]       slot_q, slot_d;
   logic [ID_W-1:0]         win_q, win_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    we_q, we_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    mem_req_q;
   logic [NUM_REQ-1:0]      layer_ack_q;
   logic [DATA_WIDTH-1:0]   layer_rdata_q;
   logic                    cpu_ack_q;
   logic [DATA_WIDTH-1:0]   cpu_rdata_q;
   logic                    hblank_q;
   logic                    overrun_q;
   logic [OVR_W-1:0]        overrun_cnt_q;

   logic                    rr_vld;
   logic [PTR_W-1:0]        rr_idx;
   logic [ADDR_WIDTH-1:0]   layer_addr_sel;
   logic                    cpu_win;
   logic                    grant_vld;
   logic                    layer_busy;
   logic                    overrun_hit;

   rr_select #(
      .N  (NUM_REQ),
      .PW (PTR_W)
   ) u_rr_select (
      .req_i (layer_req),
      .ptr_i (ptr_q),
      .vld_o (rr_vld),
      .idx_o (rr_idx)
   );

   assign layer_addr_sel = layer_addr[rr_idx*ADDR_WIDTH +: ADDR_WIDTH];

   // Winner selection: CPU owns vblank, gets a reserved slot in active video, else round-robin layers
   always_comb begin
      cpu_win   = cpu_req && (vblank || (slot_q >= SLOT_PERIOD) || !rr_vld);
      grant_vld = cpu_req || rr_vld;
      win_d     = CPU_ID;
      addr_d    = cpu_addr;
      we_d      = cpu_we;
      wdata_d   = cpu_wdata;
      ptr_d     = ptr_q;
      slot_d    = '0;
      if (!cpu_win) begin
         win_d   = ID_W'(rr_idx);
         addr_d  = layer_addr_sel;
         we_d    = 1'b0;
         wdata_d = '0;
         ptr_d   = rr_idx;
         slot_d  = (slot_q == SLOT_MAX) ? slot_q : slot_q + SLOT_W'(1);
      end
   end

   // Grant sequencer: latch the winner, hold the memory request, return data with a one-cycle ack
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         ptr_q         <= PTR_W'(NUM_REQ - 1);
         slot_q        <= '0;
         win_q         <= '0;
         addr_q        <= '0;
         we_q          <= 1'b0;
         wdata_q       <= '0;
         mem_req_q     <= 1'b0;
         layer_ack_q   <= '0;
         layer_rdata_q <= '0;
         cpu_ack_q     <= 1'b0;
         cpu_rdata_q   <= '0;
      end else begin
         layer_ack_q <= '0;
         cpu_ack_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_vld) begin
                  win_q     <= win_d;
                  addr_q    <= addr_d;
                  we_q      <= we_d;
                  wdata_q   <= wdata_d;
                  ptr_q     <= ptr_d;
                  slot_q    <= slot_d;
                  mem_req_q <= 1'b1;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  we_q      <= 1'b0;
                  if (win_q == CPU_ID) begin
                     cpu_ack_q   <= 1'b1;
                     cpu_rdata_q <= mem_rdata;
                  end else begin
                     layer_ack_q   <= NUM_REQ'(1) << win_q;
                     layer_rdata_q <= mem_rdata;
                  end
                  state_q <= DONE;
               end
            end
            DONE: begin
               // Requesters may drop req on this edge; IDLE samples only from the next cycle
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // A layer fetch still in flight counts as unfinished work for the overrun check
   assign layer_busy  = (state_q != IDLE) && (win_q != CPU_ID);
   assign overrun_hit = hblank && !hblank_q && !vblank && ((|layer_req) || layer_busy);

   // Line overrun: pulse and saturating count when hblank starts with layer work outstanding
   always_ff @(posedge clk) begin
      if (reset) begin
         hblank_q      <= 1'b0;
         overrun_q     <= 1'b0;
         overrun_cnt_q <= '0;
      end else begin
         hblank_q  <= hblank;
         overrun_q <= overrun_hit;
         if (overrun_hit && (overrun_cnt_q != OVR_MAX)) begin
            overrun_cnt_q <= overrun_cnt_q + OVR_W'(1);
         end
      end
   end

   assign mem_req       = mem_req_q;
   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign layer_ack     = layer_ack_q;
   assign layer_rdata   = layer_rdata_q;
   assign cpu_ack       = cpu_ack_q;
   assign cpu_rdata     = cpu_rdata_q;
   assign line_overrun  = overrun_q;
   assign overrun_count = overrun_cnt_q;

endmodule

// File: doc/video_mem_arbiter.md
Name: video_mem_arbiter

Overview:
- Shares one tile/VRAM memory port between NUM_REQ per-scanline layer fetch engines and the CPU.
- Scheduling policy follows the raster position:
  - During active display, layer fetches are served round-robin, with one grant reserved for the CPU every CPU_SLOT_PERIOD layer grants.
  - During vblank, the CPU has strict priority.
- Flags scanlines where a layer fetch is still pending when hblank begins (line overrun).
- Sits between the video timing generator, the layer renderers and the memory controller.

Parameters:
- NUM_REQ, 4, number of layer requesters (2..8).
- ADDR_WIDTH, 20, memory word address width.
- DATA_WIDTH, 32, memory data width.
- CPU_SLOT_PERIOD, 4, layer grants after which a pending CPU request must win (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- hblank  in  1  from timing generator
- vblank  in  1  from timing generator
- layer_req  in  NUM_REQ  per-layer read request, level
- layer_addr  in  NUM_REQ*ADDR_WIDTH  flattened; layer i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- layer_ack  out  NUM_REQ  one-cycle pulse, layer_rdata valid
- layer_rdata  out  DATA_WIDTH  read data, shared by all layers
- cpu_req  in  1  CPU request, level
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_ack  out  1  one-cycle pulse; cpu_rdata valid for reads
- cpu_rdata  out  DATA_WIDTH  CPU read data
- mem_req  out  1  held high until mem_ack
- mem_we  out  1  write strobe qualifier
- mem_addr  out  ADDR_WIDTH  stable while mem_req is high
- mem_wdata  out  DATA_WIDTH  stable while mem_req is high
- mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_WIDTH  memory read data
- line_overrun  out  1  one-cycle pulse
- overrun_count  out  8  saturating count of overruns

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, round-robin pointer = NUM_REQ-1 (so layer 0 is searched first), slot counter 0, hblank_d 0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - Evaluate requests. If any are pending, latch the winner id, address, we and wdata; go to ISSUE.
  - mem_req is asserted on the next cycle. Latency from req sampled to mem_req is 1 cycle.
- ISSUE:
  - mem_req = 1; mem_addr, mem_we and mem_wdata hold the latched values.
  - On mem_ack: register mem_rdata into the winner's rdata output and go to DONE.
- DONE:
  - The winner's ack is high for exactly this cycle; mem_req = 0.
  - Return to IDLE.
  - The minimum grant-to-grant spacing is 3 cycles plus memory latency.
- Requester contract: hold req, addr and data stable until ack; drop req on the edge ending the ack cycle, or keep it high to request again. IDLE never samples during DONE, so no duplicate grant occurs.
- Winner selection in IDLE:
  - cpu_req and vblank → CPU.
  - cpu_req and slot_cnt >= CPU_SLOT_PERIOD → CPU.
  - cpu_req and no layer_req → CPU.
  - Otherwise, the first layer_req at or after index ptr+1, searching modulo NUM_REQ.
- Round-robin pointer: updated to the granted layer index on a layer grant; unchanged on a CPU grant.
- slot_cnt (4 bits): increments on each layer grant, saturating at 15; cleared on a CPU grant.
- Layer requests are still served during vblank, but only when cpu_req is low.
- Overrun detection:
  - hblank_d is registered every cycle.
  - On a rising edge of hblank (hblank & ~hblank_d), if any layer_req bit is high, or a layer grant is in ISSUE/DONE: pulse line_overrun and increment overrun_count, saturating at 255.
  - Overrun detection is suppressed while vblank = 1.
- Simultaneous events: a CPU request and a layer request arriving in the same cycle follow the selection rules above. A mem_ack arriving outside ISSUE is ignored.
- Reset mid-transaction: mem_req drops on the next edge and no ack is issued for the aborted request. The memory controller is reset by the same signal.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package (video_pkg):
  - FSM state encoding (IDLE/ISSUE/DONE).
  - Requester-id width: clog2(NUM_REQ+1).
  - CPU_ID constant = NUM_REQ.
- One sub-module, rr_select: a combinational round-robin priority picker taking req vector and pointer, returning a valid flag and index. It is reused by the sprite and line-buffer schedulers.

Test Plan:
- Layers 0..3 all requesting, cpu_req=0, vblank=0, mem_ack 2 cycles after mem_req → grant order 0,1,2,3,0; each layer_ack pulses once with the matching mem_rdata.
- All layers continuously requesting plus cpu_req=1 during active display, CPU_SLOT_PERIOD=4 → CPU granted after every 4th layer grant; slot_cnt returns to 0 after each CPU grant.
- vblank=1, cpu_req and layer_req=4'b1111 → CPU wins every arbitration until cpu_req drops; then layers resume from ptr+1.
- CPU write, addr=0x12345, data=0xDEADBEEF → mem_we=1 with addr and data stable from mem_req high through mem_ack; cpu_ack pulses one cycle after mem_ack.
- layer_req[2] held high when hblank rises with vblank=0 → line_overrun pulses one cycle and overrun_count goes 0→1; with vblank=1 there is no pulse. Force 300 overruns → count saturates at 255.
- Assert reset while in ISSUE → mem_req=0 on the next cycle, no layer_ack or cpu_ack pulse, overrun_count=0, first grant after release goes to layer 0.
